inst_fetch_resp: RTL and testbench

//  Responder for the core's instruction-fetch port (ce/addr out, inst in). Replaces the zero-wait ROM.

---
 rtl/inst_fetch_resp.sv | 158 +++++++++++++++
 tb/tb_inst_fetch_resp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves core fetches from a one-line buffer and refills the
// line from backing memory over a req/ack handshake, stalling the pipeline while it fills.
// Optional hit/miss statistics counters are enabled by defining IFETCH_STATS_EN.
module inst_fetch_resp #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       inst_o,
    output logic              stallreq_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned IdxW = $clog2(LINE_WORDS);
    localparam int unsigned OffW = IdxW + 2;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   tag_q, tag_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [31:0]         line_q [LINE_WORDS];
    logic                line_we;

    logic [ADDR_W-1:0]   base;
    logic [IdxW-1:0]     widx;
    logic                hit;
    logic                last_word;
    logic                unused_addr;

    assign base        = {addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
    assign widx        = addr_i[OffW-1:2];
    assign hit         = ce_i & valid_q & (base == tag_q);
    assign last_word   = (cnt_q == IdxW'(LINE_WORDS - 1));
    // Byte offset within a word is irrelevant for 32-bit fetches.
    assign unused_addr = ^addr_i[1:0];

    assign mem_req_o  = req_q;
    assign mem_addr_o = maddr_q;

    // Control state: FSM, line tag/valid, fill counter and memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
        end
    end

    // Line data needs no reset: it is only visible once valid is set by a complete fill.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[cnt_q] <= mem_data_i;
        end
    end

    // Next-state logic: start a linear refill on a miss, capture one word per ack.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        maddr_d = maddr_q;
        line_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ce_i && !hit) begin
                    state_d = StFill;
                    tag_d   = base;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    maddr_d = base;
                end
            end
            StFill: begin
                if (mem_ack_i) begin
                    line_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    maddr_d = maddr_q + ADDR_W'(4);
                    if (last_word) begin
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Core-facing outputs; forced low while reset is asserted.
    always_comb begin
        inst_o     = 32'h0;
        stallreq_o = 1'b0;
        if (rst && ce_i) begin
            if (state_q == StIdle && hit) begin
                inst_o = line_q[widx];
            end else begin
                stallreq_o = 1'b1;
            end
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (state_q == StIdle && hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == StIdle && ce_i && !hit && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp (LINE_WORDS=4). Backing memory returns addr^0xA5A5_0000;
// acks are driven so that a cold miss stalls for cycles 0..9 and hits at cycle 10.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;
`ifdef IFETCH_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch_resp #(
        .LINE_WORDS(4),
        .ADDR_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce_i),
        .addr_i    (addr_i),
        .inst_o    (inst_o),
        .stallreq_o(stallreq_o),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i (mem_ack_i),
        .mem_data_i(mem_data_i)
`ifdef IFETCH_STATS_EN
        ,
        .hit_cnt_o (hit_cnt_o),
        .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic [31:0] addr);
        next_cycle();
        ce_i   = ce;
        addr_i = addr;
        #2;
    endtask

    // Runs refill cycles 1..10 after a miss at cycle 0. Acks land on cycles 3,5,7,9.
    // When drop_after is n>0, ce is dropped in the cycle after the n-th ack.
    task automatic fill(input logic [31:0] base, input int drop_after);
        logic [31:0] a;
        int          gap;
        logic        drop;
        drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a   = base + 32'(4 * i);
            gap = (i == 0) ? 3 : 2;
            for (int c = 0; c < gap; c++) begin
                next_cycle();
                if (drop) ce_i = 1'b0;
                mem_ack_i  = (c == gap - 1);
                mem_data_i = mem_ack_i ? (a ^ 32'hA5A5_0000) : 32'h0;
                #2;
                chk("fill_req", {31'b0, mem_req_o}, 32'd1);
                chk("fill_addr", mem_addr_o, a);
                chk("fill_stall", {31'b0, stallreq_o}, {31'b0, ce_i});
                chk("fill_inst", inst_o, 32'h0);
            end
            if (i + 1 == drop_after) drop = 1'b1;
        end
        next_cycle();
        mem_ack_i  = 1'b0;
        mem_data_i = 32'h0;
        #2;
        chk("fill_done_req", {31'b0, mem_req_o}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b1;

        // 1: cold fetch of line 0
        drive(1'b1, 32'h0000_0000);
        chk("t1_miss_stall", {31'b0, stallreq_o}, 32'd1);
        chk("t1_miss_inst", inst_o, 32'h0);
        chk("t1_miss_req", {31'b0, mem_req_o}, 32'd0);
        fill(32'h0000_0000, 0);
        chk("t1_hit_stall", {31'b0, stallreq_o}, 32'd0);
        chk("t1_hit_inst", inst_o, 32'hA5A5_0000);

        // 2: streaming hits, then the next line misses
        drive(1'b1, 32'h0000_0004);
        chk("t2_inst4", inst_o, 32'hA5A5_0004);
        chk("t2_stall4", {31'b0, stallreq_o}, 32'd0);
        drive(1'b1, 32'h0000_0008);
        chk("t2_inst8", inst_o, 32'hA5A5_0008);
        drive(1'b1, 32'h0000_000C);
        chk("t2_instC", inst_o, 32'hA5A5_000C);
        chk("t2_stallC", {31'b0, stallreq_o}, 32'd0);
        drive(1'b1, 32'h0000_0010);
        chk("t2_bound_stall", {31'b0, stallreq_o}, 32'd1);
        chk("t2_bound_inst", inst_o, 32'h0);
        fill(32'h0000_0010, 0);
`ifdef IFETCH_STATS_EN
        chk("t6_miss_cnt", miss_cnt_o, 32'd2);
        chk("t6_hit_cnt", hit_cnt_o, 32'd4);
`endif
        chk("t2_hit10", inst_o, 32'hA5A5_0010);

`ifdef IFETCH_STATS_EN
        // 6: hit counter saturates
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        drive(1'b1, 32'h0000_0014);
        chk("t6_sat_pre", hit_cnt_o, 32'hFFFF_FFFF);
        next_cycle();
        #2;
        chk("t6_sat", hit_cnt_o, 32'hFFFF_FFFF);
`endif

        // 3: unaligned address selects the containing word
        drive(1'b1, 32'h0000_0106);
        chk("t3_miss_stall", {31'b0, stallreq_o}, 32'd1);
        fill(32'h0000_0100, 0);
        chk("t3_inst", inst_o, 32'hA5A5_0104);
        chk("t3_stall", {31'b0, stallreq_o}, 32'd0);

        // 4: ce drops mid-fill; refill still completes and later hits
        drive(1'b1, 32'h0000_0200);
        chk("t4_miss_stall", {31'b0, stallreq_o}, 32'd1);
        fill(32'h0000_0200, 2);
        chk("t4_idle_stall", {31'b0, stallreq_o}, 32'd0);
        chk("t4_idle_inst", inst_o, 32'h0);
        drive(1'b1, 32'h0000_0208);
        chk("t4_hit_inst", inst_o, 32'hA5A5_0208);
        chk("t4_hit_stall", {31'b0, stallreq_o}, 32'd0);
        chk("t4_no_req", {31'b0, mem_req_o}, 32'd0);
        next_cycle();
        #2;
        chk("t4_no_req2", {31'b0, mem_req_o}, 32'd0);

        // 5: reset during a fill aborts it; stray ack ignored; same address refills from base
        drive(1'b1, 32'h0000_0304);
        chk("t5_miss_stall", {31'b0, stallreq_o}, 32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h0000_0300 ^ 32'hA5A5_0000;
        #2;
        chk("t5_pre_addr", mem_addr_o, 32'h0000_0300);
        next_cycle();
        mem_data_i = 32'hDEAD_BEEF;
        rst = 1'b0;
        #2;
        chk("t5_rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("t5_rst_stall", {31'b0, stallreq_o}, 32'd0);
        chk("t5_rst_maddr", mem_addr_o, 32'h0);
        next_cycle();
        rst = 1'b1;
        #2;
        chk("t5_stray_stall", {31'b0, stallreq_o}, 32'd1);
        chk("t5_stray_req", {31'b0, mem_req_o}, 32'd0);
        chk("t5_stray_inst", inst_o, 32'h0);
        fill(32'h0000_0300, 0);
        chk("t5_hit_inst", inst_o, 32'hA5A5_0304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
